// File: rtl/tx_framing_pkg.sv
// Shared TX framing definitions: framing select encodings, sync header codes
// and block geometry used by the framing FSM and the lane gearbox.
package tx_framing_pkg;

  localparam int unsigned SYMBOLS_PER_BLOCK = 16;
  localparam int unsigned SYNC_HDR_WIDTH    = 2;

  // Header value bit 0 goes on the wire first.
  localparam logic [SYNC_HDR_WIDTH-1:0] SYNC_HDR_DATA = 2'b10;
  localparam logic [SYNC_HDR_WIDTH-1:0] SYNC_HDR_OS   = 2'b01;

  typedef enum logic [1:0] {
    FRAM_SEL_IDLE = 2'b00,
    FRAM_SEL_OS   = 2'b01,
    FRAM_SEL_32   = 2'b10,
    FRAM_SEL_1    = 2'b11
  } fram_sel_e;

  function automatic logic [SYNC_HDR_WIDTH-1:0] sync_header(input logic sync_sel);
    return sync_sel ? SYNC_HDR_OS : SYNC_HDR_DATA;
  endfunction

endpackage

// File: rtl/tx_block_symbol_counter.sv
// Symbol index within a block: counts accepted symbols modulo SYMBOLS_PER_BLOCK.
module tx_block_symbol_counter
  import tx_framing_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_En,
  output logic [COUNT_WIDTH-1:0] o_Count
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(SYMBOLS_PER_BLOCK - 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      o_Count <= '0;
    end else if (i_En) begin
      o_Count <= (o_Count == LAST_IDX) ? '0 : o_Count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/tx_gearbox_one_lane.sv
// Single-lane 128b/130b TX gearbox: inserts sync headers at block start and
// repacks the 130-bit blocks into serializer bytes, stalling once per 4 blocks.
module tx_gearbox_one_lane
  import tx_framing_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH     = 8,
  parameter int unsigned SYMBOL_NUM_WIDTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_Enable,
  input  logic [1:0]                  i_Fram_Sel,
  input  logic [SYMBOL_WIDTH-1:0]     i_Framed_Data,
  input  logic [SYMBOL_WIDTH-1:0]     i_Os_Symbol,
  input  logic                        i_Sync_Sel,
  output logic                        o_EN,
  output logic [SYMBOL_NUM_WIDTH-1:0] o_Symbol_Num,
  output logic [SYMBOL_WIDTH-1:0]     o_Tx_Data,
  output logic                        o_Tx_Valid
);

  localparam int unsigned BUF_WIDTH = 2 * SYMBOL_WIDTH;
  localparam int unsigned RES_WIDTH = $clog2(BUF_WIDTH + 1);
  localparam logic [RES_WIDTH-1:0] RES_FULL = RES_WIDTH'(SYMBOL_WIDTH);

  logic [BUF_WIDTH-1:0]        res_buf;
  logic [BUF_WIDTH-1:0]        res_buf_nxt;
  logic [RES_WIDTH-1:0]        res_cnt;
  logic [RES_WIDTH-1:0]        res_cnt_nxt;
  logic [SYMBOL_NUM_WIDTH-1:0] sym_num;
  logic [SYMBOL_WIDTH-1:0]     sym_sel;
  logic [BUF_WIDTH-1:0]        new_bits;
  logic [BUF_WIDTH-1:0]        merged;
  logic [SYMBOL_WIDTH-1:0]     tx_byte_nxt;
  logic                        tx_load;
  logic                        hdr_slot;
  logic                        stall;

  tx_block_symbol_counter #(
    .COUNT_WIDTH (SYMBOL_NUM_WIDTH)
  ) u_sym_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .i_En    (o_EN),
    .o_Count (sym_num)
  );

  // Residual buffer is full exactly when a block boundary needs a spare byte slot.
  always_comb begin
    hdr_slot     = (sym_num == '0);
    stall        = i_Enable && hdr_slot && (res_cnt == RES_FULL);
    o_EN         = i_Enable && !stall && !RST;
    o_Symbol_Num = sym_num;
  end

  always_comb begin
    sym_sel = '0;
    unique case (fram_sel_e'(i_Fram_Sel))
      FRAM_SEL_IDLE: sym_sel = '0;
      FRAM_SEL_OS:   sym_sel = i_Os_Symbol;
      FRAM_SEL_32,
      FRAM_SEL_1:    sym_sel = i_Framed_Data;
      default:       sym_sel = '0;
    endcase
  end

  // New bits land above the residual; the low byte always leaves on an accept.
  always_comb begin
    new_bits    = hdr_slot ? BUF_WIDTH'({sym_sel, sync_header(i_Sync_Sel)})
                           : BUF_WIDTH'(sym_sel);
    merged      = res_buf | (new_bits << res_cnt);
    res_buf_nxt = res_buf;
    res_cnt_nxt = res_cnt;
    tx_load     = 1'b0;
    tx_byte_nxt = merged[SYMBOL_WIDTH-1:0];
    if (stall) begin
      tx_load     = 1'b1;
      tx_byte_nxt = res_buf[SYMBOL_WIDTH-1:0];
      res_buf_nxt = '0;
      res_cnt_nxt = '0;
    end else if (o_EN) begin
      tx_load     = 1'b1;
      res_buf_nxt = merged >> SYMBOL_WIDTH;
      res_cnt_nxt = hdr_slot ? res_cnt + RES_WIDTH'(SYNC_HDR_WIDTH) : res_cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_buf    <= '0;
      res_cnt    <= '0;
      o_Tx_Data  <= '0;
      o_Tx_Valid <= 1'b0;
    end else begin
      res_buf    <= res_buf_nxt;
      res_cnt    <= res_cnt_nxt;
      o_Tx_Valid <= tx_load;
      if (tx_load) begin
        o_Tx_Data <= tx_byte_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tx_gearbox_one_lane.sv
// Scoreboard bench for tx_gearbox_one_lane against a bit-queue reference model.
module tb_tx_gearbox_one_lane;

  logic       CLK = 1'b0;
  logic       RST;
  logic       i_Enable;
  logic [1:0] i_Fram_Sel;
  logic [7:0] i_Framed_Data;
  logic [7:0] i_Os_Symbol;
  logic       i_Sync_Sel;
  logic       o_EN;
  logic [3:0] o_Symbol_Num;
  logic [7:0] o_Tx_Data;
  logic       o_Tx_Valid;

  always #5 CLK = ~CLK;

  tx_gearbox_one_lane #(
    .SYMBOL_WIDTH     (8),
    .SYMBOL_NUM_WIDTH (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_Enable      (i_Enable),
    .i_Fram_Sel    (i_Fram_Sel),
    .i_Framed_Data (i_Framed_Data),
    .i_Os_Symbol   (i_Os_Symbol),
    .i_Sync_Sel    (i_Sync_Sel),
    .o_EN          (o_EN),
    .o_Symbol_Num  (o_Symbol_Num),
    .o_Tx_Data     (o_Tx_Data),
    .o_Tx_Valid    (o_Tx_Valid)
  );

  typedef struct packed {
    logic       en;
    logic       num_chk;
    logic [3:0] num;
  } ctrl_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } out_t;

  ctrl_t      q_ctrl[$];
  out_t       q_out[$];
  bit         bitq[$];
  int         idx = 0;
  logic [7:0] last_byte = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;

  // Reference: wire bits as a queue; header then symbol, LSB first, 8 bits per byte out.
  task automatic drive(input logic rst, input logic en, input logic [1:0] fsel,
                       input logic [7:0] fdata, input logic [7:0] os, input logic ss);
    ctrl_t      c;
    out_t       o;
    logic [7:0] sym;
    logic [1:0] hdr;
    logic [7:0] b;
    @(posedge CLK);
    #1;
    RST = rst; i_Enable = en; i_Fram_Sel = fsel;
    i_Framed_Data = fdata; i_Os_Symbol = os; i_Sync_Sel = ss;
    cyc++;
    c.en = 1'b0; c.num_chk = !rst; c.num = 4'(idx);
    o.vld = 1'b0; o.data = last_byte;
    if (rst) begin
      idx = 0; bitq.delete(); last_byte = 8'h00; o.data = 8'h00;
    end else if (en) begin
      if (idx == 0 && bitq.size() == 8) begin
        b = 8'h00;
      end else begin
        c.en = 1'b1;
        sym = (fsel == 2'b00) ? 8'h00 : (fsel == 2'b01) ? os : fdata;
        if (idx == 0) begin
          hdr = ss ? 2'b01 : 2'b10;
          bitq.push_back(hdr[0]);
          bitq.push_back(hdr[1]);
        end
        for (int k = 0; k < 8; k++) bitq.push_back(sym[k]);
        idx = (idx + 1) % 16;
      end
      for (int k = 0; k < 8; k++) b[k] = bitq.pop_front();
      o.vld = 1'b1; o.data = b; last_byte = b;
    end
    q_ctrl.push_back(c);
    q_out.push_back(o);
  endtask

  ctrl_t mc;
  out_t  mo;

  // Monitor: combinational strobes checked this cycle, registered byte from last cycle.
  always @(negedge CLK) begin
    if (q_ctrl.size() > 0) begin
      mc = q_ctrl.pop_front();
      n_vec++;
      if (o_EN !== mc.en) begin
        n_err++;
        $display("FAIL o_EN cyc=%0d got=%0b exp=%0b", cyc, o_EN, mc.en);
      end
      if (mc.num_chk) begin
        n_vec++;
        if (o_Symbol_Num !== mc.num) begin
          n_err++;
          $display("FAIL sym_num cyc=%0d got=%0d exp=%0d", cyc, o_Symbol_Num, mc.num);
        end
      end
    end
    if (q_out.size() >= 2) begin
      mo = q_out.pop_front();
      n_vec++;
      if (o_Tx_Valid !== mo.vld || o_Tx_Data !== mo.data) begin
        n_err++;
        $display("FAIL tx_byte cyc=%0d got vld=%0b data=%02h exp vld=%0b data=%02h",
                 cyc, o_Tx_Valid, o_Tx_Data, mo.vld, mo.data);
      end
    end
  end

  task automatic run_until_idx(input int target, input logic ss);
    int guard = 0;
    while (idx != target && guard < 80) begin
      drive(1'b0, 1'b1, 2'b11, 8'($urandom), 8'h00, ss);
      guard++;
    end
    if (idx != target) begin
      n_vec++; n_err++;
      $display("FAIL seek_idx got=%0d exp=%0d", idx, target);
    end
  endtask

  initial begin
    RST = 1'b1; i_Enable = 1'b0; i_Fram_Sel = 2'b00;
    i_Framed_Data = 8'h00; i_Os_Symbol = 8'h00; i_Sync_Sel = 1'b0;

    repeat (3) drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);

    // IDLE data blocks: 02 then zeros
    repeat (20) drive(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);

    // Full 4-block superframe with incrementing framed data
    repeat (2) drive(1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 260; k++) drive(1'b0, 1'b1, 2'b11, 8'(k), 8'h00, 1'b0);

    // OS block with AA symbols
    repeat (2) drive(1'b1, 1'b0, 2'b01, 8'h00, 8'hAA, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 2'b01, 8'h00, 8'hAA, 1'b1);

    // Enable gap at symbol 7
    run_until_idx(7, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 2'b11, 8'h5C, 8'h00, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 2'b11, 8'($urandom), 8'h00, 1'b0);

    // Reset mid-block at symbol 9
    run_until_idx(9, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 8'h33, 8'h00, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 2'b11, 8'($urandom), 8'h00, 1'b1);

    // Sync select flips mid-block
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    run_until_idx(5, 1'b0);
    repeat (30) drive(1'b0, 1'b1, 2'b11, 8'($urandom), 8'h00, 1'b1);

    // Stall deferred by enable drop across a superframe boundary
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    repeat (64) drive(1'b0, 1'b1, 2'b11, 8'($urandom), 8'h00, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b0);
    repeat (4) drive(1'b0, 1'b1, 2'b11, 8'($urandom), 8'h00, 1'b1);

    // Random traffic
    for (int k = 0; k < 700; k++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (3) drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
